// File: rtl/strm_cmd_framer.sv
// Command-driven stream framer: emits one header word {op, params} followed by
// LEN payload words taken from the input stream, with m_tlast on the final word.
module strm_cmd_framer #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [27:0]      cmd_params,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [DW-1:0]    s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [DW-1:0]    m_tdata,
    output logic             m_tlast,
    output logic             cmd_err,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t      state;
    logic [15:0] remaining;
    logic        cmd_hs;
    logic        in_hs;
    logic        out_hs;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0100: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    assign cmd_ready = (state == IDLE);
    assign s_tready  = (state == DATA) && (remaining != 16'd0) && (!m_tvalid || m_tready);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign in_hs     = s_tvalid && s_tready;
    assign out_hs    = m_tvalid && m_tready;

    // The output register doubles as the header capture: m_tlast on the
    // header word already records whether LEN was zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= 16'd0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tlast    <= 1'b0;
            cmd_err    <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            cmd_err    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        if (op_legal(cmd_op)) begin
                            remaining <= cmd_params[15:0];
                            m_tvalid  <= 1'b1;
                            m_tdata   <= DW'({cmd_op, cmd_params});
                            m_tlast   <= (cmd_params[15:0] == 16'd0);
                            state     <= HEADER;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (out_hs) begin
                        m_tvalid <= 1'b0;
                        if (m_tlast) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (in_hs) begin
                        m_tvalid  <= 1'b1;
                        m_tdata   <= s_tdata;
                        m_tlast   <= (remaining == 16'd1);
                        remaining <= remaining - 16'd1;
                    end else if (out_hs) begin
                        m_tvalid <= 1'b0;
                    end
                    // No load can coincide with the last word draining: remaining is already 0.
                    if (out_hs && m_tlast) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_strm_cmd_framer.sv
// Scoreboard bench for strm_cmd_framer: expected frames are queued at issue
// time and a monitor compares every output handshake against them.
module tb_strm_cmd_framer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'd0;
    logic [27:0] cmd_params = 28'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = 32'd0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        cmd_err;
    logic        frame_done;
    logic [15:0] frame_cnt;

    logic        c2_valid = 1'b0;
    logic        c2_ready;
    logic        c2_s_tready;
    logic        c2_m_tvalid;
    logic [31:0] c2_m_tdata;
    logic        c2_m_tlast;
    logic        c2_err;
    logic        c2_done;
    logic [1:0]  c2_cnt;

    strm_cmd_framer #(.DW(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_params(cmd_params),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .cmd_err(cmd_err), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    // Narrow frame counter instance used to reach the wrap point quickly.
    strm_cmd_framer #(.DW(32), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_op(4'd0), .cmd_params(28'd0),
        .s_tvalid(1'b0), .s_tready(c2_s_tready), .s_tdata(32'd0),
        .m_tvalid(c2_m_tvalid), .m_tready(1'b1), .m_tdata(c2_m_tdata), .m_tlast(c2_m_tlast),
        .cmd_err(c2_err), .frame_done(c2_done), .frame_cnt(c2_cnt)
    );

    int          total = 0;
    int          bad = 0;
    logic [32:0] exp_q[$];
    bit          throttle = 1'b0;
    int          model_frames = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_d = 32'd0;
    logic        prev_l = 1'b0;
    bit          exp_done = 1'b0;
    logic [3:0]  legal_ops[4] = '{4'd0, 4'd1, 4'd2, 4'd4};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out or missing event", name);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (exp_done) begin
                check("frame_done_pulse", 32'(frame_done), 32'd1);
                model_frames++;
                check("frame_cnt", 32'(frame_cnt), 32'(model_frames[15:0]));
            end else if (frame_done) begin
                check("frame_done_spurious", 32'(frame_done), 32'd0);
            end
            exp_done = 1'b0;
            if (prev_stall) begin
                check("hold_valid", 32'(m_tvalid), 32'd1);
                check("hold_data", m_tdata, prev_d);
                check("hold_last", 32'(m_tlast), 32'(prev_l));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h expected no word", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("m_tdata", m_tdata, e[31:0]);
                    check("m_tlast", 32'(m_tlast), 32'(e[32]));
                    if (e[32]) exp_done = 1'b1;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        s_tvalid = 1'b0;
        c2_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        exp_q.delete();
        model_frames = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [27:0] params);
        int  n = 0;
        bit  ok = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_params = params;
        forever begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
            if (n > 200) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (!ok) fail_now("cmd_accept");
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        forever begin
            @(posedge clk);
            #1;
            s_tvalid = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_tdata = w;
            @(negedge clk);
            if (s_tvalid && s_tready) break;
            n++;
            if (n > 500) begin
                fail_now("payload_accept");
                break;
            end
        end
    endtask

    // Queues the expected header + payload, then issues the command and sends
    // nsend payload words (all of them when nsend < 0).
    task automatic send_frame(input logic [3:0] op, input logic [11:0] user, input int len,
                              input bit fixed, input int nsend);
        logic [31:0] w[$];
        int          cnt;
        for (int i = 0; i < len; i++) w.push_back(fixed ? 32'hA + 32'(i) : $urandom());
        exp_q.push_back({(len == 0), op, user, 16'(len)});
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), w[i]});
        send_cmd(op, {user, 16'(len)});
        cnt = (nsend < 0) ? len : nsend;
        for (int i = 0; i < cnt; i++) send_word(w[i]);
        if (nsend < 0) begin
            @(posedge clk);
            #1;
            s_tvalid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain");
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int pulses;
        int n;
        do_reset();

        // op=1, LEN=3, payload A,B,C
        send_frame(4'd1, 12'd0, 3, 1'b1, -1);
        wait_drain();
        check("frame_cnt_after_first", 32'(frame_cnt), 32'd1);

        // op=0, LEN=0: header only, with m_tlast
        send_frame(4'd0, 12'd0, 0, 1'b1, -1);
        wait_drain();
        check("frame_cnt_after_len0", 32'(frame_cnt), 32'd2);
        check("idle_after_len0", 32'(cmd_ready), 32'd1);

        // illegal op is rejected with a single cmd_err pulse
        send_cmd(4'd3, 28'h0000005);
        s_tvalid = 1'b1;
        @(negedge clk);
        check("cmd_err_pulse", 32'(cmd_err), 32'd1);
        check("illegal_no_valid", 32'(m_tvalid), 32'd0);
        check("s_tready_outside_data", 32'(s_tready), 32'd0);
        @(negedge clk);
        check("cmd_err_one_cycle", 32'(cmd_err), 32'd0);
        check("illegal_no_valid_2", 32'(m_tvalid), 32'd0);
        check("frame_cnt_after_illegal", 32'(frame_cnt), 32'd2);
        s_tvalid = 1'b0;
        send_frame(4'd2, 12'h5A5, 2, 1'b0, -1);
        wait_drain();

        // randomized throttling on both sides
        throttle = 1'b1;
        for (int f = 0; f < 12; f++) begin
            send_frame(legal_ops[$urandom_range(0, 3)], 12'($urandom()),
                       (f < 4) ? 4 : $urandom_range(0, 7), 1'b0, -1);
            wait_drain();
        end
        throttle = 1'b0;
        repeat (3) @(negedge clk);
        check("frame_cnt_after_random", 32'(frame_cnt), 32'd15);

        // reset after the second payload word of an 8-word frame
        send_frame(4'd1, 12'h123, 8, 1'b0, 2);
        do_reset();
        repeat (4) @(negedge clk);
        check("no_output_after_reset", 32'(m_tvalid), 32'd0);
        send_frame(4'd4, 12'h0FF, 3, 1'b0, -1);
        wait_drain();
        check("frame_cnt_fresh_frame", 32'(frame_cnt), 32'd1);

        // frame counter wrap on the narrow instance
        do_reset();
        @(posedge clk);
        #1;
        c2_valid = 1'b1;
        pulses = 0;
        n = 0;
        while (pulses < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (c2_done) begin
                pulses++;
                if (pulses == 3) check("wrap_at_max", 32'(c2_cnt), 32'd3);
                if (pulses == 4) check("wrap_to_zero", 32'(c2_cnt), 32'd0);
            end
        end
        c2_valid = 1'b0;
        if (pulses < 4) fail_now("wrap_frames");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
